// File: rtl/core_pkg.sv
// Shared core types: register/data widths, bypass source encoding and hit-vector helper.
// Imported by the operand fetch stage, its bypass mux and the stage interface.
package core_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  // Bit positions inside a per-source bypass hit vector
  localparam int HIT_EX  = 2;
  localparam int HIT_MEM = 1;
  localparam int HIT_WB  = 0;
  localparam int HIT_W   = 3;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_e;

  function automatic logic [HIT_W-1:0] hit_vec(
    input logic                 ex_ok,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic                 mem_wen,
    input logic [REG_IDX_W-1:0] mem_rd,
    input logic                 wb_wen,
    input logic [REG_IDX_W-1:0] wb_rd,
    input logic [REG_IDX_W-1:0] src
  );
    logic [HIT_W-1:0] h;
    h          = '0;
    h[HIT_EX]  = ex_ok   && (ex_rd  == src);
    h[HIT_MEM] = mem_wen && (mem_rd == src);
    h[HIT_WB]  = wb_wen  && (wb_rd  == src);
    return h;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle between decode / reg_file / later stages and the operand fetch stage.
// master = surrounding pipeline, slave = the operand fetch stage itself.
interface operand_fetch_stage_if
  import core_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
);

  logic                 id_valid;
  logic                 id_ready;
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [REG_IDX_W-1:0] id_rd;
  logic                 id_rd_wen;
  logic                 id_is_load;
  logic [XLEN-1:0]      id_imm;
  logic [CTRL_W-1:0]    id_ctrl;

  logic [REG_IDX_W-1:0] rf_rd1_addr;
  logic [REG_IDX_W-1:0] rf_rd2_addr;
  logic [XLEN-1:0]      rf_r1;
  logic [XLEN-1:0]      rf_r2;

  logic [XLEN-1:0]      ex_fwd_data;
  logic                 mem_wen;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [XLEN-1:0]      mem_data;
  logic                 wb_wen;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;

  logic                 flush;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      ex_rs1_val;
  logic [XLEN-1:0]      ex_rs2_val;
  logic [XLEN-1:0]      ex_imm;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_rd_wen;
  logic                 ex_is_load;
  logic [CTRL_W-1:0]    ex_ctrl;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wen,
           id_is_load, id_imm, id_ctrl,
    output rf_r1, rf_r2, ex_fwd_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data,
    output flush, out_ready,
    input  id_ready, rf_rd1_addr, rf_rd2_addr, out_valid,
    input  ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_wen, ex_is_load, ex_ctrl, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wen,
           id_is_load, id_imm, id_ctrl,
    input  rf_r1, rf_r2, ex_fwd_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data,
    input  flush, out_ready,
    output id_ready, rf_rd1_addr, rf_rd2_addr, out_valid,
    output ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rd_wen, ex_is_load, ex_ctrl, stall_cnt
  );

endinterface

// File: rtl/operand_bypass_mux.sv
// Per-source operand select: x0, then EX, MEM, WB bypass, then reg_file read data.
// Purely combinational; one instance per source register.
module operand_bypass_mux
  import core_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 use_src,
  input  logic [HIT_W-1:0]     hit,
  input  logic [XLEN-1:0]      ex_data,
  input  logic [XLEN-1:0]      mem_data,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [XLEN-1:0]      rf_data,
  output fwd_sel_e             sel,
  output logic [XLEN-1:0]      val
);

  // An unread source needs no bypass; the raw reg_file value is as good as any.
  always_comb begin
    sel = FWD_RF;
    if (idx == '0)
      sel = FWD_ZERO;
    else if (!use_src)
      sel = FWD_RF;
    else if (hit[HIT_EX])
      sel = FWD_EX;
    else if (hit[HIT_MEM])
      sel = FWD_MEM;
    else if (hit[HIT_WB])
      sel = FWD_WB;
  end

  always_comb begin
    val = rf_data;
    case (sel)
      FWD_ZERO: val = '0;
      FWD_EX:   val = ex_data;
      FWD_MEM:  val = mem_data;
      FWD_WB:   val = wb_data;
      default:  val = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID->EX operand stage: bypass resolution, load-use stall, ID/EX register with valid/ready and flush.
// One cycle ID->EX; holds while EX back-pressures; one bubble per load-use dependency.
module operand_fetch_stage
  import core_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
)(
  input logic                clk,
  input logic                rst,
  operand_fetch_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [XLEN-1:0]      imm;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_wen;
    logic                 is_load;
    logic [CTRL_W-1:0]    ctrl;
  } idex_t;

  idex_t            ex_q;
  idex_t            ex_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             ex_fwd_ok;
  logic             ex_ld_ok;
  logic [HIT_W-1:0] hit1;
  logic [HIT_W-1:0] hit2;
  fwd_sel_e         sel1;
  fwd_sel_e         sel2;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic             hz1;
  logic             hz2;
  logic             hz;
  logic             adv;

  assign ex_fwd_ok = out_valid_q && ex_q.rd_wen && !ex_q.is_load;
  assign ex_ld_ok  = out_valid_q && ex_q.rd_wen &&  ex_q.is_load;

  assign hit1 = hit_vec(ex_fwd_ok, ex_q.rd, bus.mem_wen, bus.mem_rd, bus.wb_wen, bus.wb_rd, bus.id_rs1);
  assign hit2 = hit_vec(ex_fwd_ok, ex_q.rd, bus.mem_wen, bus.mem_rd, bus.wb_wen, bus.wb_rd, bus.id_rs2);

  operand_bypass_mux u_byp1 (
    .idx      (bus.id_rs1),
    .use_src  (bus.id_use_rs1),
    .hit      (hit1),
    .ex_data  (bus.ex_fwd_data),
    .mem_data (bus.mem_data),
    .wb_data  (bus.wb_data),
    .rf_data  (bus.rf_r1),
    .sel      (sel1),
    .val      (op1)
  );

  operand_bypass_mux u_byp2 (
    .idx      (bus.id_rs2),
    .use_src  (bus.id_use_rs2),
    .hit      (hit2),
    .ex_data  (bus.ex_fwd_data),
    .mem_data (bus.mem_data),
    .wb_data  (bus.wb_data),
    .rf_data  (bus.rf_r2),
    .sel      (sel2),
    .val      (op2)
  );

  // A load into x0 never stalls: sel is FWD_ZERO exactly when the source index is 0.
  assign hz1 = bus.id_use_rs1 && ex_ld_ok && (ex_q.rd == bus.id_rs1) && (sel1 != FWD_ZERO);
  assign hz2 = bus.id_use_rs2 && ex_ld_ok && (ex_q.rd == bus.id_rs2) && (sel2 != FWD_ZERO);
  assign hz  = bus.id_valid && (hz1 || hz2);

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.id_ready = (adv && !hz) || bus.flush;

  assign bus.rf_rd1_addr = bus.id_rs1;
  assign bus.rf_rd2_addr = bus.id_rs2;

  always_comb begin
    ex_d         = '0;
    ex_d.rs1_val = op1;
    ex_d.rs2_val = op2;
    ex_d.imm     = bus.id_imm;
    ex_d.rd      = bus.id_rd;
    ex_d.rd_wen  = bus.id_rd_wen;
    ex_d.is_load = bus.id_is_load;
    ex_d.ctrl    = bus.id_ctrl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (adv) begin
        if (hz) begin
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= bus.id_valid;
          ex_q        <= ex_d;
        end
      end

      if (hz && !bus.flush && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.ex_rs1_val = ex_q.rs1_val;
  assign bus.ex_rs2_val = ex_q.rs2_val;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_rd_wen  = ex_q.rd_wen;
  assign bus.ex_is_load = ex_q.is_load;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: vector table for bypass selection,
// hand sequences for load-use, back-pressure/flush, counter saturation and async reset.
module tb_operand_fetch_stage;

  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;

  operand_fetch_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  operand_fetch_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [31:0] rf_r1;
    logic [31:0] rf_r2;
    logic [31:0] ex_fwd;
    logic        mem_wen;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rd_wen, input logic is_load, input logic [31:0] imm);
    bus.id_valid   = 1'b1;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_use_rs1 = 1'b1;
    bus.id_use_rs2 = 1'b1;
    bus.id_rd      = rd;
    bus.id_rd_wen  = rd_wen;
    bus.id_is_load = is_load;
    bus.id_imm     = imm;
    bus.id_ctrl    = imm[15:0];
  endtask

  task automatic drive_byp(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exf,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] md,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
    bus.rf_r1       = r1;
    bus.rf_r2       = r2;
    bus.ex_fwd_data = exf;
    bus.mem_wen     = mw;
    bus.mem_rd      = mrd;
    bus.mem_data    = md;
    bus.wb_wen      = ww;
    bus.wb_rd       = wrd;
    bus.wb_data     = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //         rs1 rs2 rd wen imm        ctrl     rf_r1     rf_r2     ex_fwd    mw mrd mem_data  ww wrd wb_data        exp1          exp2
    vec[0] = '{5,  6,  10, 0, 32'h100,   16'h0001, 32'h0,    32'h66,   32'h0,    0, 0, 32'h0,    1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h66};
    vec[1] = '{1,  2,  7,  1, 32'h200,   16'h0002, 32'h1,    32'h2,    32'hAAAA, 0, 0, 32'h0,    0, 0, 32'h0,        32'h1,        32'h2};
    vec[2] = '{3,  7,  0,  0, 32'h300,   16'h0003, 32'h3,    32'h44,   32'h11,   1, 7, 32'h22,   1, 7, 32'h33,       32'h3,        32'h11};
    vec[3] = '{7,  7,  0,  0, 32'h400,   16'h0004, 32'h77,   32'h77,   32'h11,   1, 7, 32'h22,   1, 7, 32'h33,       32'h22,       32'h22};
    vec[4] = '{7,  8,  0,  0, 32'h500,   16'h0005, 32'h77,   32'h88,   32'h0,    0, 0, 32'h0,    1, 7, 32'h33,       32'h33,       32'h88};
    vec[5] = '{0,  0,  0,  0, 32'h600,   16'h0006, 32'h55,   32'h56,   32'h99,   1, 0, 32'hFFFF, 1, 0, 32'h123,      32'h0,        32'h0};
    vec[6] = '{4,  4,  9,  1, 32'h700,   16'h0007, 32'h40,   32'h40,   32'h0,    0, 0, 32'h0,    0, 0, 32'h0,        32'h40,       32'h40};
    vec[7] = '{9,  9,  0,  0, 32'h800,   16'h0008, 32'h90,   32'h90,   32'hCAFE, 1, 9, 32'hBAD,  1, 9, 32'hBEE,      32'hCAFE,     32'hCAFE};

    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive_id(0, 0, 0, 0, 0, 32'h0);
    bus.id_valid = 1'b0;
    drive_byp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("reset_ex_imm",    bus.ex_imm, 32'h0);
    chk("reset_ex_rs1",    bus.ex_rs1_val, 32'h0);
    chk("reset_id_ready",  32'(bus.id_ready), 32'h1);
    tick();
    rst = 1'b0;

    // Table: each row enters ID while the previous row sits in EX
    for (int i = 0; i < 8; i++) begin
      drive_id(vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].rd_wen, 1'b0, vec[i].imm);
      bus.id_ctrl = vec[i].ctrl;
      drive_byp(vec[i].rf_r1, vec[i].rf_r2, vec[i].ex_fwd, vec[i].mem_wen, vec[i].mem_rd,
                vec[i].mem_data, vec[i].wb_wen, vec[i].wb_rd, vec[i].wb_data);
      #1;
      chk($sformatf("v%0d_id_ready", i), 32'(bus.id_ready), 32'h1);
      chk($sformatf("v%0d_rf_addr2", i), 32'(bus.rf_rd2_addr), 32'(vec[i].rs2));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
      chk($sformatf("v%0d_rs1", i), bus.ex_rs1_val, vec[i].exp1);
      chk($sformatf("v%0d_rs2", i), bus.ex_rs2_val, vec[i].exp2);
      chk($sformatf("v%0d_imm", i), bus.ex_imm, vec[i].imm);
      chk($sformatf("v%0d_ctrl", i), 32'(bus.ex_ctrl), 32'(vec[i].ctrl));
      chk($sformatf("v%0d_rd", i), 32'({bus.ex_rd_wen, bus.ex_rd}), 32'({vec[i].rd_wen, vec[i].rd}));
    end

    // Load-use with EX/MEM/WB all targeting x7
    drive_id(0, 0, 7, 1, 1, 32'hA00);
    drive_byp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ld_in_ex", 32'({bus.out_valid, bus.ex_is_load}), 32'h3);
    drive_id(1, 7, 0, 0, 0, 32'hB00);
    drive_byp(32'h1, 32'h44, 32'h11, 1, 7, 32'h22, 1, 7, 32'h33);
    #1;
    chk("lu_id_ready_low", 32'(bus.id_ready), 32'h0);
    tick();
    chk("lu_bubble", 32'(bus.out_valid), 32'h0);
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'h1);
    chk("lu_id_ready_back", 32'(bus.id_ready), 32'h1);
    tick();
    chk("lu_out_valid", 32'(bus.out_valid), 32'h1);
    chk("lu_rs2_from_mem", bus.ex_rs2_val, 32'h22);
    chk("lu_rs1", bus.ex_rs1_val, 32'h1);
    chk("lu_imm", bus.ex_imm, 32'hB00);
    chk("lu_stall_cnt_hold", 32'(bus.stall_cnt), 32'h1);

    // Back-pressure for 3 cycles, then flush
    drive_id(2, 3, 0, 0, 0, 32'hC00);
    drive_byp(32'h1234, 32'h5678, 0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_id_ready", c), 32'(bus.id_ready), 32'h0);
      tick();
      chk($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'h1);
      chk($sformatf("bp%0d_imm", c), bus.ex_imm, 32'hB00);
      chk($sformatf("bp%0d_rs2", c), bus.ex_rs2_val, 32'h22);
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_id_ready", 32'(bus.id_ready), 32'h1);
    tick();
    chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    // Stall counting under back-pressure, flush suppression, then saturation
    drive_id(0, 0, 4, 1, 1, 32'hD00);
    tick();
    drive_id(4, 0, 0, 0, 0, 32'hE00);
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("cnt_after_3", 32'(bus.stall_cnt), 32'h4);
    chk("cnt_ld_held", 32'(bus.ex_imm), 32'hD00);
    bus.flush = 1'b1;
    tick();
    chk("cnt_flush_no_inc", 32'(bus.stall_cnt), 32'h4);
    chk("cnt_flush_valid", 32'(bus.out_valid), 32'h0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive_id(0, 0, 4, 1, 1, 32'hD00);
    tick();
    drive_id(4, 0, 0, 0, 0, 32'hE00);
    bus.out_ready = 1'b0;
    repeat (15) tick();
    chk("cnt_saturated", 32'(bus.stall_cnt), 32'hF);
    chk("sat_id_ready", 32'(bus.id_ready), 32'h0);

    // Asynchronous reset mid-stream: takes effect without a clock edge
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("arst_ex_rd", 32'(bus.ex_rd), 32'h0);
    tick();
    rst = 1'b0;
    bus.id_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
